// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - PikaRISC register file bus: IF pc, EXE read ports, WB write ports.
interface reg_file_if;
    logic [31:0] if_pc_in;
    logic [31:0] if_pc_out;
    logic [3:0]  exe_rd_num;
    logic [31:0] exe_rd_data_out;
    logic [3:0]  exe_rs_num;
    logic [31:0] exe_rs_data_out;
    logic [3:0]  exe_rt_num;
    logic [31:0] exe_rt_data_out;
    logic [31:0] exe_cpsr_out;
    logic [3:0]  wb_rd_num;
    logic        wb_rd_write_en;
    logic [31:0] wb_rd_in;
    logic        wb_cpsr_write_en;
    logic [31:0] wb_cpsr_in;

    modport master (
        output if_pc_in, exe_rd_num, exe_rs_num, exe_rt_num,
               wb_rd_num, wb_rd_write_en, wb_rd_in, wb_cpsr_write_en, wb_cpsr_in,
        input  if_pc_out, exe_rd_data_out, exe_rs_data_out, exe_rt_data_out, exe_cpsr_out
    );

    modport slave (
        input  if_pc_in, exe_rd_num, exe_rs_num, exe_rt_num,
               wb_rd_num, wb_rd_write_en, wb_rd_in, wb_cpsr_write_en, wb_cpsr_in,
        output if_pc_out, exe_rd_data_out, exe_rs_data_out, exe_rt_data_out, exe_cpsr_out
    );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 16x32 GPRs, PC and CPSR with three write-first bypassed read ports.
module reg_file (
    input  logic         clk,
    input  logic         reset,
    reg_file_if.slave    bus
);
    logic [31:0] r_gpr [16];
    logic [31:0] r_pc;
    logic [31:0] r_cpsr;

    logic w_rd_hit;
    logic w_rs_hit;
    logic w_rt_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                r_gpr[i] <= 32'h0;
            end
            r_pc   <= 32'h0;
            r_cpsr <= 32'h0;
        end else begin
            r_pc <= bus.if_pc_in;
            if (bus.wb_rd_write_en) begin
                r_gpr[bus.wb_rd_num] <= bus.wb_rd_in;
            end
            if (bus.wb_cpsr_write_en) begin
                r_cpsr <= bus.wb_cpsr_in;
            end
        end
    end

    // Write-first: a port reading the register being written sees the new value now.
    assign w_rd_hit = bus.wb_rd_write_en && (bus.exe_rd_num == bus.wb_rd_num);
    assign w_rs_hit = bus.wb_rd_write_en && (bus.exe_rs_num == bus.wb_rd_num);
    assign w_rt_hit = bus.wb_rd_write_en && (bus.exe_rt_num == bus.wb_rd_num);

    assign bus.exe_rd_data_out = w_rd_hit ? bus.wb_rd_in : r_gpr[bus.exe_rd_num];
    assign bus.exe_rs_data_out = w_rs_hit ? bus.wb_rd_in : r_gpr[bus.exe_rs_num];
    assign bus.exe_rt_data_out = w_rt_hit ? bus.wb_rd_in : r_gpr[bus.exe_rt_num];
    assign bus.exe_cpsr_out    = bus.wb_cpsr_write_en ? bus.wb_cpsr_in : r_cpsr;
    assign bus.if_pc_out       = r_pc;
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed scoreboard bench for reg_file.
module tb_reg_file;
    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    logic [31:0] q_exp [$];

    reg_file_if u_bus ();

    reg_file u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input logic [31:0] v);
        q_exp.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        n_total++;
        if (q_exp.size() == 0) begin
            $error("FAIL %s scoreboard empty observed=%h", tag, obs);
        end else begin
            exp_v = q_exp.pop_front();
            assert (obs === exp_v) n_pass++;
            else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        expect_val(32'h0); check({tag, "_pc"},   u_bus.if_pc_out);
        expect_val(32'h0); check({tag, "_rd"},   u_bus.exe_rd_data_out);
        expect_val(32'h0); check({tag, "_rs"},   u_bus.exe_rs_data_out);
        expect_val(32'h0); check({tag, "_rt"},   u_bus.exe_rt_data_out);
        expect_val(32'h0); check({tag, "_cpsr"}, u_bus.exe_cpsr_out);
    endtask

    task automatic set_idx(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        u_bus.exe_rd_num = a;
        u_bus.exe_rs_num = b;
        u_bus.exe_rt_num = c;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset = 1'b0;
        u_bus.if_pc_in         = 32'h0;
        u_bus.wb_rd_num        = 4'h0;
        u_bus.wb_rd_write_en   = 1'b0;
        u_bus.wb_rd_in         = 32'h0;
        u_bus.wb_cpsr_write_en = 1'b0;
        u_bus.wb_cpsr_in       = 32'h0;
        set_idx(4'd3, 4'd3, 4'd3);
        #1;
        check_all_zero("reset_init");
        step();
        reset = 1'b1;
        step();

        // Preload R3, PC and CPSR, then assert reset mid-cycle.
        u_bus.wb_rd_write_en   = 1'b1;
        u_bus.wb_rd_num        = 4'd3;
        u_bus.wb_rd_in         = 32'h1234;
        u_bus.if_pc_in         = 32'd7;
        u_bus.wb_cpsr_write_en = 1'b1;
        u_bus.wb_cpsr_in       = 32'd5;
        step();
        u_bus.wb_rd_write_en   = 1'b0;
        u_bus.wb_cpsr_write_en = 1'b0;
        u_bus.if_pc_in         = 32'd9;
        #1;
        expect_val(32'd7);    check("preload_pc",   u_bus.if_pc_out);
        expect_val(32'h1234); check("preload_r3",   u_bus.exe_rd_data_out);
        expect_val(32'd5);    check("preload_cpsr", u_bus.exe_cpsr_out);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("reset_async");
        u_bus.wb_rd_write_en   = 1'b1;
        u_bus.wb_rd_in         = 32'hBEEF;
        u_bus.wb_cpsr_write_en = 1'b1;
        u_bus.wb_cpsr_in       = 32'h77;
        step();
        u_bus.wb_rd_write_en   = 1'b0;
        u_bus.wb_cpsr_write_en = 1'b0;
        #1;
        check_all_zero("reset_held");
        #1;
        reset = 1'b1;
        u_bus.if_pc_in = 32'h0;
        step();
        check_all_zero("reset_release");

        // PC sweep
        for (int v = 0; v < 44; v++) begin
            u_bus.if_pc_in = v;
            expect_val(v);
            step();
            check($sformatf("pc_%0d", v), u_bus.if_pc_out);
        end
        expect_val(32'h0); check("pc_sweep_r3",   u_bus.exe_rd_data_out);
        expect_val(32'h0); check("pc_sweep_cpsr", u_bus.exe_cpsr_out);

        // CPSR bypass and store
        for (int v = 0; v < 16; v++) begin
            u_bus.wb_cpsr_write_en = 1'b1;
            u_bus.wb_cpsr_in       = v;
            #1;
            expect_val(v); check($sformatf("cpsr_byp_%0d", v), u_bus.exe_cpsr_out);
            step();
            u_bus.wb_cpsr_write_en = 1'b0;
            u_bus.wb_cpsr_in       = 32'hFF;
            #1;
            expect_val(v); check($sformatf("cpsr_hold_%0d", v), u_bus.exe_cpsr_out);
        end
        step();
        expect_val(32'd15); check("cpsr_disabled", u_bus.exe_cpsr_out);

        // GPR sweep with same-cycle bypass on all three ports
        u_bus.wb_rd_write_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            u_bus.wb_rd_num = i;
            u_bus.wb_rd_in  = i;
            set_idx(i, i, i);
            #1;
            expect_val(i); check($sformatf("byp_rd_%0d", i), u_bus.exe_rd_data_out);
            expect_val(i); check($sformatf("byp_rs_%0d", i), u_bus.exe_rs_data_out);
            expect_val(i); check($sformatf("byp_rt_%0d", i), u_bus.exe_rt_data_out);
            step();
        end
        u_bus.wb_rd_write_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            set_idx(k, 15 - k, (k + 5) % 16);
            #1;
            expect_val(k);            check($sformatf("rd_%0d", k), u_bus.exe_rd_data_out);
            expect_val(15 - k);       check($sformatf("rs_%0d", 15 - k), u_bus.exe_rs_data_out);
            expect_val((k + 5) % 16); check($sformatf("rt_%0d", (k + 5) % 16), u_bus.exe_rt_data_out);
        end

        // Independent ports
        u_bus.wb_rd_write_en = 1'b1;
        u_bus.wb_rd_num = 4'd1; u_bus.wb_rd_in = 32'hA; step();
        u_bus.wb_rd_num = 4'd2; u_bus.wb_rd_in = 32'hB; step();
        u_bus.wb_rd_num = 4'd3; u_bus.wb_rd_in = 32'hC; step();
        u_bus.wb_rd_write_en = 1'b0;
        set_idx(4'd1, 4'd2, 4'd3);
        #1;
        expect_val(32'hA); check("indep_rd", u_bus.exe_rd_data_out);
        expect_val(32'hB); check("indep_rs", u_bus.exe_rs_data_out);
        expect_val(32'hC); check("indep_rt", u_bus.exe_rt_data_out);
        set_idx(4'd2, 4'd2, 4'd2);
        #1;
        expect_val(32'hB); check("same_rd", u_bus.exe_rd_data_out);
        expect_val(32'hB); check("same_rs", u_bus.exe_rs_data_out);
        expect_val(32'hB); check("same_rt", u_bus.exe_rt_data_out);

        // Disabled write must neither bypass nor store
        u_bus.wb_rd_num = 4'd4;
        u_bus.wb_rd_in  = 32'hDEAD;
        set_idx(4'd4, 4'd4, 4'd4);
        #1;
        expect_val(32'd4); check("dis_nobyp_rd", u_bus.exe_rd_data_out);
        expect_val(32'd4); check("dis_nobyp_rt", u_bus.exe_rt_data_out);
        step();
        expect_val(32'd4); check("dis_r4_rd", u_bus.exe_rd_data_out);
        expect_val(32'd4); check("dis_r4_rs", u_bus.exe_rs_data_out);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
